// File: rtl/pwm_fader.sv
// Control stage ahead of the PWM: derives the step tick and walks the duty word
// toward a requested target, changing it only on PWM period boundaries.
module pwm_fader #(
    parameter int N        = 8,
    parameter int PRESCALE = 250,
    parameter int RATE_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [N-1:0]      target,
    input  logic [RATE_W-1:0] rate,
    input  logic              target_valid,
    output logic              target_ready,
    output logic              step,
    output logic [N-1:0]      duty,
    output logic              period_end,
    output logic              busy
);

    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
    localparam logic [N-1:0]  PCNT_MAX = {N{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [PW-1:0]       pre_r;
    logic [N-1:0]        pcnt_r;
    logic [N-1:0]        duty_r;
    logic [N-1:0]        duty_nxt_s;
    logic [N-1:0]        duty_move_s;
    logic [N-1:0]        tgt_r;
    logic [N-1:0]        tgt_nxt_s;
    logic [RATE_W-1:0]   rate_r;
    logic [RATE_W-1:0]   rate_nxt_s;
    logic [RATE_W-1:0]   rcnt_r;
    logic [RATE_W-1:0]   rcnt_nxt_s;
    logic [RATE_W-1:0]   rcnt_inc_s;
    logic                step_s;
    logic                period_end_s;
    logic                xfer_s;

    // PRESCALE=1 collapses to step=ena because PRE_MAX is then zero
    assign step_s       = ena & (pre_r == PRE_MAX);
    assign period_end_s = step_s & (pcnt_r == PCNT_MAX);
    assign xfer_s       = target_valid & (state_r == IDLE);
    assign rcnt_inc_s   = rcnt_r + RATE_W'(1);

    assign step         = step_s;
    assign period_end   = period_end_s;
    assign duty         = duty_r;
    assign busy         = (state_r == RAMP);
    assign target_ready = (state_r == IDLE);

    // Prescaler: counts enabled cycles, wrapping on the step tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_r <= {PW{1'b0}};
        end else if (step_s) begin
            pre_r <= {PW{1'b0}};
        end else if (ena) begin
            pre_r <= pre_r + PW'(1);
        end else begin
            pre_r <= pre_r;
        end
    end

    // Period tracker: shadows the downstream PWM counter, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_r <= {N{1'b0}};
        end else if (step_s) begin
            pcnt_r <= pcnt_r + N'(1);
        end else begin
            pcnt_r <= pcnt_r;
        end
    end

    // One-unit move toward the latched target; never overshoots it
    always_comb begin
        duty_move_s = duty_r;
        if (tgt_r > duty_r) begin
            duty_move_s = duty_r + N'(1);
        end else if (tgt_r < duty_r) begin
            duty_move_s = duty_r - N'(1);
        end else begin
            duty_move_s = duty_r;
        end
    end

    // Fade FSM next-state: offers accepted in IDLE, progress only on period_end
    always_comb begin
        state_nxt_s = state_r;
        duty_nxt_s  = duty_r;
        tgt_nxt_s   = tgt_r;
        rate_nxt_s  = rate_r;
        rcnt_nxt_s  = rcnt_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    tgt_nxt_s  = target;
                    rate_nxt_s = rate;
                    rcnt_nxt_s = {RATE_W{1'b0}};
                    if (target != duty_r) begin
                        state_nxt_s = RAMP;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RAMP: begin
                if (period_end_s) begin
                    if (rate_r == {RATE_W{1'b0}}) begin
                        duty_nxt_s  = tgt_r;
                        rcnt_nxt_s  = {RATE_W{1'b0}};
                        state_nxt_s = IDLE;
                    end else if (rcnt_inc_s == rate_r) begin
                        rcnt_nxt_s = {RATE_W{1'b0}};
                        duty_nxt_s = duty_move_s;
                        if (duty_move_s == tgt_r) begin
                            state_nxt_s = IDLE;
                        end else begin
                            state_nxt_s = RAMP;
                        end
                    end else begin
                        rcnt_nxt_s  = rcnt_inc_s;
                        state_nxt_s = RAMP;
                    end
                end else begin
                    state_nxt_s = RAMP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Fade FSM state and datapath registers; reset abandons any ramp
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            duty_r  <= {N{1'b0}};
            tgt_r   <= {N{1'b0}};
            rate_r  <= {RATE_W{1'b0}};
            rcnt_r  <= {RATE_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            duty_r  <= duty_nxt_s;
            tgt_r   <= tgt_nxt_s;
            rate_r  <= rate_nxt_s;
            rcnt_r  <= rcnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_pwm_fader.sv
// Bench for pwm_fader: per-cycle comparison against a period/elapsed-time model,
// plus an offer table and hand sequences for step spacing and async reset.
module tb_pwm_fader;

    localparam int N        = 4;
    localparam int PRESCALE = 3;
    localparam int RATE_W   = 4;
    localparam int PERIOD   = PRESCALE * (1 << N);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ena = 1'b0;
    logic [N-1:0]      target = '0;
    logic [RATE_W-1:0] rate = '0;
    logic              target_valid = 1'b0;
    logic              target_ready;
    logic              step;
    logic [N-1:0]      duty;
    logic              period_end;
    logic              busy;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state: elapsed enabled cycles and the ramp in progress
    int m_t       = 0;
    int m_duty    = 0;
    int m_tgt     = 0;
    int m_rate    = 0;
    int m_periods = 0;
    bit m_busy    = 1'b0;
    bit o_step;
    bit o_pe;

    typedef struct {
        logic [N-1:0]      tgt;
        logic [RATE_W-1:0] rt;
        int                exp_duty;
        int                exp_periods;
    } vec_t;

    vec_t tbl[9];

    always #5 clk = ~clk;

    pwm_fader #(.N(N), .PRESCALE(PRESCALE), .RATE_W(RATE_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .target       (target),
        .rate         (rate),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .step         (step),
        .duty         (duty),
        .period_end   (period_end),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // one clock: compare at negedge+1, advance model on posedge, return at negedge
    task automatic tick();
        bit ms;
        bit mp;
        #1;
        ms = ena && (m_t % PRESCALE == PRESCALE - 1);
        mp = ms && (m_t % PERIOD == PERIOD - 1);
        o_step = step;
        o_pe   = period_end;
        check("step", step, ms);
        check("period_end", period_end, mp);
        check("duty", duty, m_duty);
        check("busy", busy, m_busy);
        check("ready", target_ready, !m_busy);
        @(posedge clk);
        if (!m_busy) begin
            if (target_valid) begin
                m_tgt     = target;
                m_rate    = rate;
                m_periods = 0;
                m_busy    = (target != m_duty);
            end
        end else if (mp) begin
            m_periods++;
            if (m_rate == 0) begin
                m_duty = m_tgt;
                m_busy = 1'b0;
            end else if (m_periods % m_rate == 0) begin
                m_duty += (m_tgt > m_duty) ? 1 : -1;
                if (m_duty == m_tgt) m_busy = 1'b0;
            end
        end
        if (ena) m_t++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        check("rst_step", step, 0);
        check("rst_period_end", period_end, 0);
        check("rst_duty", duty, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", target_ready, 1);
        m_t = 0; m_duty = 0; m_tgt = 0; m_rate = 0; m_periods = 0; m_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps;
        int pes;
        int gap;
        int guard;

        tbl[0] = '{4'd3,  4'd3, 3,  9};
        tbl[1] = '{4'd0,  4'd0, 0,  1};
        tbl[2] = '{4'd9,  4'd0, 9,  1};
        tbl[3] = '{4'd9,  4'd2, 9,  0};
        tbl[4] = '{4'd15, 4'd0, 15, 1};
        tbl[5] = '{4'd13, 4'd1, 13, 2};
        tbl[6] = '{4'd5,  4'd0, 5,  1};
        tbl[7] = '{4'd5,  4'd2, 5,  0};
        tbl[8] = '{4'd1,  4'd1, 1,  4};

        apply_reset();

        // free-running tick and period cadence
        ena = 1'b1;
        steps = 0; pes = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (o_step) steps++;
            if (o_pe) pes++;
        end
        check("steps_in_200", steps, 66);
        check("period_ends_in_200", pes, 4);

        // ena gap of 10 cycles stretches the step spacing to 13
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!o_step && guard < 6);
        check("found_step", o_step, 1);
        tick();
        gap = 1;
        ena = 1'b0;
        repeat (10) tick();
        gap += 10;
        ena = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            gap++;
            if (o_step) break;
        end
        check("step_gap", gap, 13);

        // offer table: final duty and number of period_ends spent ramping
        for (int i = 0; i < 9; i++) begin
            target = tbl[i].tgt;
            rate   = tbl[i].rt;
            target_valid = 1'b1;
            check("offer_ready", target_ready, 1);
            tick();
            target_valid = 1'b0;
            pes = 0; guard = 0;
            while (busy && guard < 5000) begin
                if (guard % 37 == 20) begin
                    target_valid = 1'b1;
                    target = 4'hf;
                    rate = 4'd0;
                end else begin
                    target_valid = 1'b0;
                end
                tick();
                if (o_pe) pes++;
                guard++;
            end
            target_valid = 1'b0;
            check("final_duty", duty, tbl[i].exp_duty);
            check("ramp_periods", pes, tbl[i].exp_periods);
        end

        // async reset in the middle of a slow ramp
        apply_reset();
        target = 4'd3; rate = 4'd3; target_valid = 1'b1;
        tick();
        target_valid = 1'b0;
        guard = 0;
        while (duty != 4'd2 && guard < 2000) begin
            tick();
            guard++;
        end
        check("mid_ramp_duty", duty, 2);
        #2;
        apply_reset();
        target = 4'd1; rate = 4'd0; target_valid = 1'b1;
        tick();
        target_valid = 1'b0;
        pes = 0; guard = 0;
        while (busy && guard < 2000) begin
            tick();
            if (o_pe) pes++;
            guard++;
        end
        check("post_reset_duty", duty, 1);
        check("post_reset_periods", pes, 1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ena          = ($urandom_range(0, 9) != 0);
            target_valid = ($urandom_range(0, 19) == 0);
            target       = 4'($urandom_range(0, 15));
            rate         = 4'($urandom_range(0, 2));
            tick();
        end
        target_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_fader.md
Name: pwm_fader

Overview:
- Upstream control stage for the etch-a-sketch PWM output.
- Produces the PWM's `step` tick from a clock prescaler.
- Produces the PWM's `duty` word, moving it toward a requested target at a programmable rate.
- Changes `duty` only at PWM period boundaries, so the downstream PWM never sees a mid-period duty change.

Parameters:
- N, 8: duty width; must match the downstream PWM's N.
- PRESCALE, 250: clock cycles per step tick; legal range >= 1.
- RATE_W, 8: width of the rate input.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low; one clock domain.
- ena  in  1  run enable for the prescaler, the period tracker and ramp progress.
- target  in  N  requested duty value.
- rate  in  RATE_W  PWM periods per duty increment; 0 means jump directly.
- target_valid  in  1  target/rate offer.
- target_ready  out  1  high while idle; a transfer occurs when valid and ready are both high on a clock edge.
- step  out  1  one-cycle tick; drives the PWM's step input.
- duty  out  N  registered duty word; drives the PWM's duty input.
- period_end  out  1  high on the step cycle that ends a PWM period.
- busy  out  1  high while ramping.

Behaviour:
- Reset (rst low, asynchronous): prescaler=0, period counter=0, rate counter=0, duty=0, state=IDLE. Resulting outputs: step=0, period_end=0, busy=0, target_ready=1. Reset mid-ramp abandons the ramp.
- Prescaler:
  - Counts 0..PRESCALE-1 while ena=1.
  - step is combinational, high when ena=1 and count==PRESCALE-1; count wraps to 0 on that edge.
  - PRESCALE=1 gives step=ena.
  - ena=0 freezes the count; step=0.
- Period tracker:
  - N-bit pcnt increments on each step and wraps at 2^N-1 -> 0, mirroring the PWM's internal counter (both reset together).
  - period_end = step & (pcnt == 2^N-1).
- FSM states: IDLE, RAMP.
  - IDLE: target_ready=1, busy=0.
    - On transfer, latch tgt_q and rate_q, and clear the rate counter.
    - If target==duty, stay IDLE (no busy pulse); otherwise go to RAMP.
    - The transfer is accepted regardless of ena.
  - RAMP: target_ready=0, busy=1; target_valid is ignored (no retargeting mid-ramp). The FSM acts only on period_end cycles:
    - rate_q==0: duty <= tgt_q; go to IDLE.
    - rate_q>0: rcnt increments. When rcnt reaches rate_q:
      - rcnt <= 0.
      - duty moves 1 toward tgt_q (+1 if tgt_q>duty, -1 if tgt_q<duty).
      - If the new duty==tgt_q, go to IDLE on the same edge.
  - ena=0 in RAMP pauses the ramp: no period_end occurs, so duty and rcnt hold.
- Latency:
  - duty updates on the rising edge at which period_end=1, so the new value is visible from the first cycle of the next period.
  - busy falls and target_ready rises on that same edge.
- Arithmetic:
  - duty is unsigned, with no wrap at 0 or 2^N-1; the ±1 step never passes tgt_q.
  - rcnt is RATE_W bits and never exceeds rate_q.

Test Plan (N=4, PRESCALE=3, RATE_W=4):
1. ena=1 for 200 clocks -> step high on every 3rd clock; period_end every 48 clocks. Then ena=0 for 10 clocks mid-count -> the gap between those steps becomes 13 clocks; duty and pcnt are unchanged.
2. From duty=0, offer target=9, rate=0 -> accepted in 1 cycle; busy=1 and ready=0 until the next period_end. duty=9 on the cycle after that period_end; busy=0 and ready=1 on the same edge.
3. From duty=0, offer target=3, rate=3 -> duty becomes 1, 2, 3 on the 3rd, 6th and 9th period_end; busy falls with the 9th; target_valid pulses during the ramp are ignored.
4. From duty=15, offer target=13, rate=1 -> duty becomes 14, then 13 on consecutive period_ends; there is no underflow past 13.
5. With duty=5, offer target=5, rate=2 -> transfer completes; busy stays 0, ready stays 1, duty stays 5.
6. Assert rst low mid-way through scenario 3 (duty=2), between clock edges -> duty=0, busy=0, ready=1 and step=0 immediately. After release, a new offer (target=1, rate=0) ramps normally.
